// File: rtl/load_store_unit_pkg.sv
// ============================================================================
//  load_store_unit_pkg : funct3 codes, FSM encoding and access-width helpers
//  Revision: 1.0
// ============================================================================
`default_nettype none

package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LD_RD  = 3'd1,
        S_LD_RSP = 3'd2,
        S_ST_RD  = 3'd3,
        S_ST_WR  = 3'd4,
        S_FAULT  = 3'd5
    } lsu_state_t;

    // funct3[1] set covers 010/011/110/111, all of which behave as full words
    function automatic logic is_word(input logic [2:0] f3);
        return f3[1];
    endfunction

    function automatic logic is_half(input logic [2:0] f3);
        return (f3[1:0] == 2'b01);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        return (is_word(f3) && (lo != 2'b00)) || (is_half(f3) && lo[0]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// ============================================================================
//  lsu_lane_align : load lane extract/extend and store lane merge (combinational)
//  Revision: 1.0
// ============================================================================
`default_nettype none

module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] mem_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = mem_word[{byte_off, 3'b000} +: 8];
    assign half_sel = byte_off[1] ? mem_word[31:16] : mem_word[15:0];

    always_comb begin
        load_data = mem_word;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_data = {24'h000000, byte_sel};
            F3_HU:   load_data = {16'h0000, half_sel};
            F3_W:    load_data = mem_word;
            default: load_data = mem_word;
        endcase
    end

    always_comb begin
        merged_word = mem_word;
        case (funct3[1:0])
            2'b00:   merged_word[{byte_off, 3'b000} +: 8] = store_data[7:0];
            2'b01:   merged_word[{byte_off[1], 4'b0000} +: 16] = store_data[15:0];
            default: merged_word = store_data;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
//  load_store_unit : MEM-stage front end to a word-only data memory, with
//  sub-word loads and read-modify-write sub-word stores.
//  Optional macro MISALIGN_TRAP_EN adds misalign_fault and a FAULT state.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_BITS = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        dm_mem_read,
    output logic        dm_mem_write,
    output logic [31:0] dm_address,
    output logic [31:0] dm_write_data,
    input  logic [31:0] dm_result
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        misalign_fault
`endif
);

    lsu_state_t             state;
    lsu_state_t             state_next;
    logic                   accept;
    logic                   lat_write;
    logic [2:0]             lat_funct3;
    logic [ADDR_BITS+1:0]   lat_addr;
    logic [31:0]            lat_wdata;
    logic [4:0]             lat_rd;
    logic [31:0]            load_data;
    logic [31:0]            merged_word;
    logic                   unused_addr_hi;

    // Address bits above the memory index are deliberately discarded (wrap).
    assign unused_addr_hi = ^req_addr[31:ADDR_BITS+2];

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid & req_ready;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
`ifdef MISALIGN_TRAP_EN
                    if (misaligned(req_funct3, req_addr[1:0]))
                        state_next = S_FAULT;
                    else
`endif
                    if (!req_write)
                        state_next = S_LD_RD;
                    else if (is_word(req_funct3))
                        state_next = S_ST_WR;
                    else
                        state_next = S_ST_RD;
                end
            end
            S_LD_RD:  state_next = S_LD_RSP;
            S_LD_RSP: state_next = S_IDLE;
            S_ST_RD:  state_next = S_ST_WR;
            S_ST_WR:  state_next = S_IDLE;
            S_FAULT:  state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            lat_write  <= 1'b0;
            lat_funct3 <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_rd     <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                lat_write  <= req_write;
                lat_funct3 <= req_funct3;
                lat_addr   <= req_addr[ADDR_BITS+1:0];
                lat_wdata  <= req_wdata;
                lat_rd     <= req_rd;
            end
        end
    end

    lsu_lane_align u_lane_align (
        .funct3      (lat_funct3),
        .byte_off    (lat_addr[1:0]),
        .mem_word    (dm_result),
        .store_data  (lat_wdata),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    // Strobes and responses are gated by reset so an aborted access leaves no trace.
    assign dm_mem_read   = !reset && ((state == S_LD_RD) || (state == S_ST_RD));
    assign dm_mem_write  = !reset && (state == S_ST_WR) && lat_write;
    assign dm_address    = {{(32-ADDR_BITS){1'b0}}, lat_addr[ADDR_BITS+1:2]};
    assign dm_write_data = merged_word;

    assign resp_valid = !reset && ((state == S_LD_RSP) || (state == S_ST_WR) || (state == S_FAULT));
    assign resp_rdata = (!reset && (state == S_LD_RSP)) ? load_data : 32'h0;
    assign resp_rd    = lat_rd;

`ifdef MISALIGN_TRAP_EN
    assign misalign_fault = !reset && (state == S_FAULT);
`endif

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
//  tb_load_store_unit : directed + random accesses against a byte-array model
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        dm_mem_read;
    logic        dm_mem_write;
    logic [31:0] dm_address;
    logic [31:0] dm_write_data;
    logic [31:0] dm_result = '0;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_fault;
`endif

    int total = 0;
    int bad   = 0;

    load_store_unit #(.ADDR_BITS(5)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_write     (req_write),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_rd        (req_rd),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_rd       (resp_rd),
        .dm_mem_read   (dm_mem_read),
        .dm_mem_write  (dm_mem_write),
        .dm_address    (dm_address),
        .dm_write_data (dm_write_data),
        .dm_result     (dm_result)
`ifdef MISALIGN_TRAP_EN
        ,
        .misalign_fault(misalign_fault)
`endif
    );

    always #5 clock = ~clock;

    // data_memory stand-in: 32 words, registered read
    logic [31:0] dmem [32];
    initial for (int i = 0; i < 32; i++) dmem[i] = i;
    always @(posedge clock) begin
        if (dm_mem_write) dmem[dm_address[4:0]] <= dm_write_data;
        if (dm_mem_read)  dm_result <= dmem[dm_address[4:0]];
    end

    // Strobe monitor
    int          n_rd = 0, n_wr = 0, n_resp = 0, clash = 0;
    logic [31:0] rd_addr, wr_addr, wr_data;
    always @(negedge clock) begin
        if (dm_mem_read)  begin n_rd++; rd_addr = dm_address; end
        if (dm_mem_write) begin n_wr++; wr_addr = dm_address; wr_data = dm_write_data; end
        if (dm_mem_read && dm_mem_write) clash++;
        if (resp_valid) n_resp++;
    end

    // Reference model: byte-addressable image of the 128-byte memory
    logic [7:0] ref_bytes [128];
    initial for (int i = 0; i < 128; i++) ref_bytes[i] = ((i % 4) == 0) ? 8'(i / 4) : 8'h00;

    function automatic logic [31:0] ref_word(input int w);
        return {ref_bytes[w*4+3], ref_bytes[w*4+2], ref_bytes[w*4+1], ref_bytes[w*4]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    logic        cur_write;
    logic [2:0]  cur_f3;
    logic [31:0] cur_addr, cur_wdata;
    logic [4:0]  cur_rd;

    task automatic drive(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
        req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
        req_valid = 1'b1;
    endtask

    task automatic set_cur(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [4:0] rd);
        cur_write = wr; cur_f3 = f3; cur_addr = a; cur_wdata = wd; cur_rd = rd;
    endtask

    task automatic wait_accept(output int waited);
        waited = 0;
        while (!req_ready && waited < 10) begin
            @(posedge clock); #1;
            waited++;
        end
        if (!req_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clock); #1;
        req_valid = 1'b0;
        n_rd = 0; n_wr = 0; n_resp = 0;
    endtask

    task automatic start(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
        int w;
        drive(wr, f3, a, wd, rd);
        set_cur(wr, f3, a, wd, rd);
        wait_accept(w);
    endtask

    task automatic finish_access();
        int a, width, base, lat, exp_lat, exp_nrd, exp_nwr;
        logic uns, flt;
        logic [15:0] h;
        logic [31:0] exp_data, exp_word;
        a     = int'(cur_addr[6:0]);
        width = cur_f3[1] ? 4 : (cur_f3[0] ? 2 : 1);
        uns   = cur_f3[2];
        base  = (width == 1) ? a : ((width == 2) ? (a & ~1) : (a & ~3));
        flt   = 1'b0;
`ifdef MISALIGN_TRAP_EN
        flt = (width == 2 && (a % 2) != 0) || (width == 4 && (a % 4) != 0);
`endif
        exp_data = 32'h0; exp_word = 32'h0;
        if (flt) begin
            exp_lat = 1; exp_nrd = 0; exp_nwr = 0;
        end else if (!cur_write) begin
            exp_lat = 2; exp_nrd = 1; exp_nwr = 0;
            if (width == 4) exp_data = ref_word(a / 4);
            else if (width == 2) begin
                h = {ref_bytes[base+1], ref_bytes[base]};
                exp_data = uns ? {16'h0, h} : {{16{h[15]}}, h};
            end else
                exp_data = uns ? {24'h0, ref_bytes[base]} : {{24{ref_bytes[base][7]}}, ref_bytes[base]};
        end else begin
            exp_lat = (width == 4) ? 1 : 2;
            exp_nrd = (width == 4) ? 0 : 1;
            exp_nwr = 1;
            for (int k = 0; k < width; k++) ref_bytes[base+k] = cur_wdata[8*k +: 8];
            exp_word = ref_word(a / 4);
        end

        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clock); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("rdata", resp_rdata, exp_data);
        check("resp_rd", {27'h0, resp_rd}, {27'h0, cur_rd});
`ifdef MISALIGN_TRAP_EN
        check("misalign_fault", {31'h0, misalign_fault}, {31'h0, flt});
`endif
        @(negedge clock); #1;
        check("n_read", 32'(n_rd), 32'(exp_nrd));
        check("n_write", 32'(n_wr), 32'(exp_nwr));
        if (exp_nrd > 0) check("rd_index", rd_addr, 32'(a / 4));
        if (exp_nwr > 0) begin
            check("wr_index", wr_addr, 32'(a / 4));
            check("wr_data", wr_data, exp_word);
        end
    endtask

    task automatic idle_step();
        @(posedge clock); #1;
        check("pulse_end", {31'h0, resp_valid}, 32'h0);
        check("ready_back", {31'h0, req_ready}, 32'h1);
    endtask

    initial begin
        int w;
        logic wr;
        logic [2:0] f3;
        logic [2:0] st_codes [6];
        st_codes = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};

        repeat (3) @(posedge clock);
        #1;
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_rd", {27'h0, resp_rd}, 32'h0);
        check("rst_strobes", {30'h0, dm_mem_read, dm_mem_write}, 32'h0);
        reset = 1'b0;

        start(1'b0, 3'b010, 32'h0C, 32'h0, 5'd5);          finish_access(); idle_step();
        start(1'b1, 3'b010, 32'h10, 32'hFFFF8081, 5'd1);    finish_access(); idle_step();
        start(1'b0, 3'b000, 32'h10, 32'h0, 5'd2);          finish_access(); idle_step();
        start(1'b0, 3'b100, 32'h10, 32'h0, 5'd3);          finish_access(); idle_step();
        start(1'b0, 3'b001, 32'h12, 32'h0, 5'd4);          finish_access(); idle_step();
        start(1'b1, 3'b000, 32'h11, 32'h123456AA, 5'd6);    finish_access(); idle_step();
        start(1'b0, 3'b010, 32'h10, 32'h0, 5'd7);          finish_access(); idle_step();

        // SH with a second request held on the bus while busy
        start(1'b1, 3'b001, 32'h16, 32'hABCD1234, 5'd8);
        drive(1'b0, 3'b010, 32'h14, 32'h0, 5'd9);
        finish_access();
        check("busy_not_ready", {31'h0, req_ready}, 32'h0);
        idle_step();
        set_cur(1'b0, 3'b010, 32'h14, 32'h0, 5'd9);
        wait_accept(w);
        check("held_accept_wait", 32'(w), 32'h0);
        finish_access(); idle_step();

        // Reset during the read phase of an SB aborts it
        start(1'b1, 3'b000, 32'h04, 32'h00000077, 5'd10);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("abort_ready", {31'h0, req_ready}, 32'h1);
        check("abort_rd", {27'h0, resp_rd}, 32'h0);
        repeat (3) @(posedge clock);
        #1;
        check("abort_writes", 32'(n_wr), 32'h0);
        check("abort_resps", 32'(n_resp), 32'h0);
        check("abort_reads", 32'(n_rd), 32'h0);
        start(1'b0, 3'b010, 32'h04, 32'h0, 5'd11);         finish_access(); idle_step();

        start(1'b0, 3'b010, 32'h0E, 32'h0, 5'd12);         finish_access(); idle_step();

        for (int i = 0; i < 200; i++) begin
            wr = 1'($urandom_range(0, 1));
            f3 = wr ? st_codes[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
            start(wr, f3, $urandom, $urandom, 5'($urandom));
            finish_access();
            if ($urandom_range(0, 3) == 0) idle_step();
        end

        check("rw_clash", 32'(clash), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
